// File: rtl/knn_topk_insert_pkg.sv
// Shared KNN types: candidate entry layout, top-k FSM states and the distance ordering helper.
// Coordinate width and list depth come from the `BIT_WIDTH / `K build macros.
`ifndef BIT_WIDTH
`define BIT_WIDTH 8
`endif
`ifndef K
`define K 4
`endif

package knn_topk_insert_pkg;

  localparam int BIT_WIDTH = `BIT_WIDTH;
  localparam int K         = `K;
  localparam int DIST_W    = 2 * BIT_WIDTH;
  localparam int ADDR_W    = 16;
  localparam int CNT_W     = $clog2(K + 1);

  typedef struct packed {
    logic [BIT_WIDTH-1:0] x;
    logic [BIT_WIDTH-1:0] y;
    logic [BIT_WIDTH-1:0] z;
    logic [ADDR_W-1:0]    addr;
    logic [DIST_W-1:0]    distance;
    logic                 valid;
  } knn_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } topk_state_e;

  // Strict unsigned ordering: an equal distance never overtakes an earlier arrival.
  function automatic logic dist_lt(input logic [DIST_W-1:0] a, input logic [DIST_W-1:0] b);
    return a < b;
  endfunction

endpackage

// File: rtl/knn_slot_cmp.sv
// Single-slot comparator: flags that a candidate belongs at or before this slot
// (slot empty, or candidate strictly nearer).
module knn_slot_cmp
  import knn_topk_insert_pkg::*;
(
  input  logic              slot_valid_i,
  input  logic [DIST_W-1:0] slot_dist_i,
  input  logic [DIST_W-1:0] cand_dist_i,
  output logic              lt_o
);

  assign lt_o = !slot_valid_i || dist_lt(cand_dist_i, slot_dist_i);

endmodule

// File: rtl/knn_topk_insert.sv
// Top-k nearest-candidate list: one-cycle parallel compare, priority encode and shift
// insertion into K sorted slots, with a done pulse once the query's last candidate lands.
module knn_topk_insert
  import knn_topk_insert_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  knn_entry_t       in_entry,
  input  logic             in_last,
  output knn_entry_t       knn_out [0:K-1],
  output logic [CNT_W-1:0] num_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] K_CNT = CNT_W'(K);

  topk_state_e      state_q;
  knn_entry_t       slot_q [0:K-1];
  knn_entry_t       slot_d [0:K-1];
  knn_entry_t       base   [0:K-1];
  knn_entry_t       ins_entry;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_base;
  logic             busy_q;
  logic             done_q;
  logic [K-1:0]     lt;
  logic [K-1:0]     first;
  logic [K-1:0]     shift;
  logic             hit;
  logic             window;
  logic             accept;

  // A start in the same cycle as a candidate means the candidate sees an already-cleared list.
  assign window   = start || (state_q == COLLECT);
  assign accept   = window && in_valid && in_entry.valid;
  assign cnt_base = start ? '0 : cnt_q;

  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_slot
      assign base[gi] = start ? '0 : slot_q[gi];

      knn_slot_cmp u_cmp (
        .slot_valid_i (base[gi].valid),
        .slot_dist_i  (base[gi].distance),
        .cand_dist_i  (in_entry.distance),
        .lt_o         (lt[gi])
      );
    end
  endgenerate

  always_comb begin
    first = '0;
    shift = '0;
    hit   = 1'b0;
    for (int i = 0; i < K; i++) begin
      shift[i] = hit;
      first[i] = lt[i] && !hit;
      hit      = hit || lt[i];
    end
  end

  always_comb begin
    ins_entry       = in_entry;
    ins_entry.valid = 1'b1;
    for (int i = 0; i < K; i++) begin
      slot_d[i] = base[i];
      if (accept) begin
        if (first[i]) begin
          slot_d[i] = ins_entry;
        end else if (shift[i]) begin
          slot_d[i] = base[(i == 0) ? 0 : i - 1];
        end
      end
    end
    cnt_d = (accept && hit && (cnt_base != K_CNT)) ? cnt_base + CNT_W'(1) : cnt_base;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      for (int i = 0; i < K; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < K; i++) begin
        slot_q[i] <= slot_d[i];
      end
      cnt_q  <= cnt_d;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      if (window) begin
        // An in_last with an invalid payload still closes the query.
        if (in_valid && in_last) begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end else begin
          state_q <= COLLECT;
          busy_q  <= 1'b1;
        end
      end else begin
        state_q <= IDLE;
      end
    end
  end

  assign knn_out   = slot_q;
  assign num_valid = cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_knn_topk_insert.sv
// Scoreboarded bench for knn_topk_insert: a queue-based reference list predicts the
// final sorted result of each query, checked when done pulses.
module tb_knn_topk_insert;
  import knn_topk_insert_pkg::*;

  typedef struct packed {
    logic [CNT_W-1:0]       n;
    knn_entry_t [K-1:0]     ent;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             in_valid;
  logic             in_last;
  knn_entry_t       in_entry;
  knn_entry_t       knn_out [0:K-1];
  logic [CNT_W-1:0] num_valid;
  logic             busy;
  logic             done;

  exp_t       sb_q[$];
  knn_entry_t model_q[$];
  bit         tb_active;
  int         n_checks   = 0;
  int         n_fail     = 0;
  int         done_count = 0;

  always #5 clk = ~clk;

  knn_topk_insert dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_entry  (in_entry),
    .in_last   (in_last),
    .knn_out   (knn_out),
    .num_valid (num_valid),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic knn_entry_t mk(input int d, input int a, input bit v);
    knn_entry_t e;
    e          = '0;
    e.x        = BIT_WIDTH'(a);
    e.y        = BIT_WIDTH'(a + 1);
    e.z        = BIT_WIDTH'(d);
    e.addr     = ADDR_W'(a);
    e.distance = DIST_W'(d);
    e.valid    = v;
    return e;
  endfunction

  // Reference: place after every kept entry with distance <= new one, then trim to K.
  task automatic model_insert(input knn_entry_t e);
    int pos;
    pos = model_q.size();
    for (int i = 0; i < model_q.size(); i++) begin
      if (model_q[i].distance > e.distance) begin
        pos = i;
        break;
      end
    end
    model_q.insert(pos, e);
    if (model_q.size() > K) void'(model_q.pop_back());
  endtask

  task automatic push_expected();
    exp_t x;
    x   = '0;
    x.n = CNT_W'(model_q.size());
    for (int i = 0; i < model_q.size(); i++) x.ent[i] = model_q[i];
    sb_q.push_back(x);
  endtask

  task automatic send(input int d, input int a, input bit v, input bit last, input bit st);
    start    = st;
    in_valid = 1'b1;
    in_last  = last;
    in_entry = mk(d, a, v);
    if (st) begin
      model_q.delete();
      tb_active = 1'b1;
    end
    if (tb_active) begin
      if (v) model_insert(in_entry);
      if (last) begin
        push_expected();
        tb_active = 1'b0;
      end
    end
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_entry = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    model_q.delete();
    tb_active = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int i;
    i = 0;
    while (done_count < target && i < 20) begin
      @(negedge clk); #1;
      i++;
    end
    check("done_seen", done_count >= target, 1);
    @(posedge clk); #1;
    check("done_is_pulse", done, 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t x;
    if (reset && done) begin
      done_count++;
      check("busy_at_done", busy, 0);
      if (sb_q.size() == 0) begin
        check("done_unexpected", 1, 0);
      end else begin
        x = sb_q.pop_front();
        check("num_valid", num_valid, x.n);
        for (int i = 0; i < K; i++) begin
          if (x.ent[i].valid) check($sformatf("slot%0d", i), knn_out[i], x.ent[i]);
          else check($sformatf("slot%0d_valid", i), knn_out[i].valid, 0);
        end
      end
    end
  end

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_entry  = '0;
    tb_active = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_num_valid", num_valid, 0);
    for (int i = 0; i < K; i++) check($sformatf("rst_slot%0d", i), knn_out[i], 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // 1: basic sort
    pulse_start();
    check("busy_collect", busy, 1);
    send(50, 1, 1, 0, 0);
    check("first_visible", knn_out[0].distance, 50);
    send(20, 2, 1, 0, 0);
    send(80, 3, 1, 0, 0);
    send(10, 4, 1, 1, 0);
    wait_done(1);
    check("busy_after_done", busy, 0);

    // 2: eviction and discard when full
    pulse_start();
    send(40, 1, 1, 0, 0);
    send(30, 2, 1, 0, 0);
    send(20, 3, 1, 0, 0);
    send(10, 4, 1, 0, 0);
    send(5, 5, 1, 0, 0);
    send(60, 6, 1, 1, 0);
    wait_done(2);

    // 3: ties keep arrival order
    pulse_start();
    send(25, 1, 1, 0, 0);
    send(25, 2, 1, 0, 0);
    send(25, 3, 1, 1, 0);
    wait_done(3);

    // 4: start, valid and last together
    send(7, 9, 1, 1, 1);
    wait_done(4);

    // 5: invalid payload skipped; IDLE input ignored
    pulse_start();
    send(9, 1, 1, 0, 0);
    send(1, 2, 0, 0, 0);
    send(3, 3, 1, 1, 0);
    wait_done(5);
    send(2, 4, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("idle_num_valid", num_valid, 2);
    check("idle_slot0", knn_out[0].distance, 3);
    check("idle_slot1", knn_out[1].distance, 9);
    check("idle_busy", busy, 0);
    check("idle_no_done", done_count, 5);

    // 6: mid-query abort gives a single done
    pulse_start();
    send(200, 1, 1, 0, 0);
    send(300, 2, 1, 0, 0);
    pulse_start();
    send(100, 3, 1, 1, 0);
    wait_done(6);
    repeat (3) @(posedge clk);
    #1;
    check("abort_one_done", done_count, 6);

    // reset asserted mid-COLLECT
    pulse_start();
    send(11, 1, 1, 0, 0);
    send(12, 2, 1, 0, 0);
    #3 reset = 1'b0;
    tb_active = 1'b0;
    model_q.delete();
    #1;
    check("mid_rst_num_valid", num_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_slot0", knn_out[0], 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_no_done", done_count, 6);
    check("sb_drained", sb_q.size(), 0);

    // random stream with frequent ties and some invalid payloads
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      send($urandom_range(0, 15), i + 1, ($urandom_range(0, 9) != 0), (i == 11), 0);
    end
    wait_done(7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
